// File: rtl/systolic_link_buffer_pkg.sv
// Shared widths for the systolic neighbour link buffer.
// DATA_BW and VSIZE mirror the tile-wide lane width and vector length.
package systolic_link_buffer_pkg;
  localparam int DATA_BW = 8;
  localparam int VSIZE   = 4;
endpackage

// File: rtl/systolic_link_buffer_if.sv
// rdy/ack vector link between neighbouring switches.
// The master owns rdy and data; the slave answers with ack.
interface systolic_link_buffer_if;
  import systolic_link_buffer_pkg::*;

  logic                            rdy;
  logic                            ack;
  logic [VSIZE-1:0][DATA_BW-1:0]   data;

  modport master (output rdy, output data, input ack);
  modport slave  (input rdy, input data, output ack);
endinterface

// File: rtl/systolic_link_buffer_chk.sv
// Runtime invariants of the link buffer: occupancy bound and legal push/pop/ack use.
module systolic_link_buffer_chk #(
  parameter int DEPTH = 2
) (
  input logic                     i_clk,
  input logic                     i_rst,
  input logic                     push,
  input logic                     pop,
  input logic                     dn_ack,
  input logic                     dn_rdy,
  input logic [$clog2(DEPTH):0]   count
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  a_count_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    count <= CNT_W'(DEPTH));
  a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && (count == CNT_W'(DEPTH))));
  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst)
    !(pop && (count == CNT_W'(0))));
  a_ack_needs_rdy: assert property (@(posedge i_clk) disable iff (i_rst)
    dn_ack |-> dn_rdy);
endmodule

// File: rtl/systolic_link_buffer.sv
// Receiving end of one directed systolic link: a small register FIFO that absorbs
// one-cycle skew between neighbouring switches without stalling the ring.
module systolic_link_buffer
  import systolic_link_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  systolic_link_buffer_if.slave    up,
  systolic_link_buffer_if.master   dn,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [VSIZE-1:0][DATA_BW-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]              wptr_r;
  logic [PTR_W-1:0]              rptr_r;
  logic [CNT_W-1:0]              count_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  // Full/empty come from occupancy so the pointers may simply wrap.
  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == CNT_W'(0));

  // up.ack looks only at local state and up.rdy, never at the downstream side.
  assign up.ack = up.rdy && !full_s && !i_clear && !i_rst;
  assign push_s = up.rdy && up.ack;
  assign pop_s  = dn.ack && !empty_s && !i_clear;

  assign dn.rdy  = !empty_s;
  assign dn.data = mem_r[rptr_r];
  assign o_count = count_r;

  // Storage, pointers and occupancy; clear flushes pointers but keeps stale data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (i_clear) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= up.data;
        wptr_r        <= wptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  systolic_link_buffer_chk #(.DEPTH(DEPTH)) u_chk (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .push   (push_s),
    .pop    (pop_s),
    .dn_ack (dn.ack),
    .dn_rdy (dn.rdy),
    .count  (count_r)
  );
endmodule

// File: tb/tb_systolic_link_buffer.sv
// Scoreboarded bench: two buffers (DEPTH 2 and 4) share one directed stimulus stream;
// the driver queues every accepted vector and a monitor checks each delivered one.
module tb_systolic_link_buffer;
  import systolic_link_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       en2 = 1'b1;
  logic       en4 = 1'b1;
  logic [1:0] cnt2;
  logic [2:0] cnt4;
  int         errors = 0;
  int         checks = 0;
  int         n4 = 0;
  logic [31:0] q2[$];
  logic [31:0] q4[$];

  systolic_link_buffer_if u2 ();
  systolic_link_buffer_if d2 ();
  systolic_link_buffer_if u4 ();
  systolic_link_buffer_if d4 ();

  systolic_link_buffer #(.DEPTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .up(u2), .dn(d2), .o_count(cnt2));
  systolic_link_buffer #(.DEPTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .up(u4), .dn(d4), .o_count(cnt4));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] v);
    logic [31:0] r;
    for (int i = 0; i < VSIZE; i++) r[i*8 +: 8] = v + 8'(i);
    return r;
  endfunction

  // One clock of stimulus; accepted vectors are queued as expected output.
  task automatic cyc(input logic ur, input logic [31:0] v, input logic want, input logic c);
    @(negedge clk);
    u2.rdy  = ur && en2;
    u4.rdy  = ur && en4;
    u2.data = v;
    u4.data = v;
    clr     = c;
    d2.ack  = want && en2 && d2.rdy;
    d4.ack  = want && en4 && d4.rdy;
    #1;
    if (c) begin
      q2.delete();
      q4.delete();
    end else begin
      if (u2.rdy && u2.ack) q2.push_back(v);
      if (u4.rdy && u4.ack) begin
        q4.push_back(v);
        n4++;
      end
    end
  endtask

  // Monitor: every transfer on a dn link must match the oldest queued vector.
  always @(negedge clk) begin
    #2;
    if (!rst && !clr) begin
      if (d2.rdy && d2.ack) begin
        if (q2.size() == 0) chk("d2_spurious_pop", 32'd1, 32'd0);
        else chk("d2_data", d2.data, q2.pop_front());
      end
      if (d4.rdy && d4.ack) begin
        if (q4.size() == 0) chk("d4_spurious_pop", 32'd1, 32'd0);
        else chk("d4_data", d4.data, q4.pop_front());
      end
    end
  end

  initial begin
    u2.rdy = 1'b0; u2.data = '0; d2.ack = 1'b0;
    u4.rdy = 1'b0; u4.data = '0; d4.ack = 1'b0;

    // Reset held two cycles with up.rdy high.
    cyc(1'b1, mk(8'h55), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h55), 1'b0, 1'b0);
    chk("rst_up_ack2", 32'(u2.ack), 32'd0);
    chk("rst_up_ack4", 32'(u4.ack), 32'd0);
    chk("rst_dn_rdy2", 32'(d2.rdy), 32'd0);
    chk("rst_count2", 32'(cnt2), 32'd0);
    chk("rst_count4", 32'(cnt4), 32'd0);
    chk("rst_data2", d2.data, 32'd0);
    chk("rst_data4", d4.data, 32'd0);
    u2.rdy = 1'b0;
    u4.rdy = 1'b0;
    rst = 1'b0;

    // Single pass: no bypass, visible one cycle after the push.
    cyc(1'b1, mk(8'h11), 1'b1, 1'b0);
    chk("single_rdy_same_cycle", 32'(d2.rdy), 32'd0);
    chk("single_count_same_cycle", 32'(cnt2), 32'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("single_rdy_next", 32'(d2.rdy), 32'd1);
    chk("single_count_next", 32'(cnt2), 32'd1);
    chk("single_rdy_next4", 32'(d4.rdy), 32'd1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("single_count_after", 32'(cnt2), 32'd0);
    chk("single_rdy_after", 32'(d2.rdy), 32'd0);

    // Fill and backpressure on the DEPTH=2 buffer only.
    en4 = 1'b0;
    cyc(1'b1, mk(8'h0A), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h0B), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h0C), 1'b0, 1'b0);
    chk("fill_count", 32'(cnt2), 32'd2);
    chk("fill_up_ack_full", 32'(u2.ack), 32'd0);
    cyc(1'b1, mk(8'h0C), 1'b1, 1'b0);
    chk("fill_up_ack_during_pop", 32'(u2.ack), 32'd0);
    cyc(1'b1, mk(8'h0C), 1'b0, 1'b0);
    chk("fill_up_ack_after_pop", 32'(u2.ack), 32'd1);
    chk("fill_count_after_pop", 32'(cnt2), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("fill_drained", 32'(cnt2), 32'd0);
    en4 = 1'b1;

    // Streaming: one push and one pop per cycle after the first fill.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, mk(8'h20 + 8'(i)), 1'b1, 1'b0);
      if (i >= 1) begin
        chk("stream_count2", 32'(cnt2), 32'd1);
        chk("stream_count4", 32'(cnt4), 32'd1);
      end
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("stream_drained2", 32'(cnt2), 32'd0);
    chk("stream_drained4", 32'(cnt4), 32'd0);

    // Pointer wrap on the DEPTH=4 buffer with random downstream stalls.
    en2 = 1'b0;
    n4 = 0;
    for (int c = 0; c < 200 && (n4 < 7 || q4.size() != 0); c++) begin
      cyc(n4 < 7, mk(8'h40 + 8'(n4)), 1'($urandom_range(1, 0)), 1'b0);
    end
    chk("wrap_pushes", 32'(n4), 32'd7);
    chk("wrap_all_delivered", 32'(q4.size()), 32'd0);
    chk("wrap_count_end", 32'(cnt4), 32'd0);
    en2 = 1'b1;

    // Clear with push and pop offered in the same cycle.
    cyc(1'b1, mk(8'h60), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h61), 1'b0, 1'b0);
    cyc(1'b1, mk(8'h62), 1'b1, 1'b1);
    chk("clr_count_before2", 32'(cnt2), 32'd2);
    chk("clr_count_before4", 32'(cnt4), 32'd2);
    chk("clr_up_ack2", 32'(u2.ack), 32'd0);
    chk("clr_up_ack4", 32'(u4.ack), 32'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("clr_count_after2", 32'(cnt2), 32'd0);
    chk("clr_count_after4", 32'(cnt4), 32'd0);
    chk("clr_rdy_after2", 32'(d2.rdy), 32'd0);
    chk("clr_rdy_after4", 32'(d4.rdy), 32'd0);
    cyc(1'b1, mk(8'h77), 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("end_queue2", 32'(q2.size()), 32'd0);
    chk("end_queue4", 32'(q4.size()), 32'd0);
    chk("end_count2", 32'(cnt2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
